uart_reg_select: RTL and testbench

Registered, parametrised register-select sequencer for the UART control path. It takes a binary register index, validates it, and drives a one-hot select onto exactly one downstream register group (baud generator, TX modulator, TX FIFO, TX shifter, and further groups as the channel count grows) for a programmable number of cycles. Accesses are sequenced with a request/busy/done handshake, and the block reports out-of-range and overrun errors. It sits between the host-side register interface and the UART sub-blocks, replacing the fixed combinational 2-to-4 select decode.

---
 rtl/uart_reg_select.sv | 118 +++++++++++
 tb/tb_uart_reg_select.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_select.sv
// Purpose: validates a binary register index and drives a held one-hot select onto one UART register group.
// Latency: select/busy rise one cycle after an accepted req; done pulses HOLD_CYC+1 cycles after it.
// Backpressure: requests made while busy are dropped and flagged on ovr; ena=1 aborts an access.
module uart_reg_select #(
    parameter int SEL_W    = 2,
    parameter int NUM_SEL  = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               req,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_SEL-1:0] sel_oh,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ovr
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    // One extra bit so the range compare stays meaningful when NUM_SEL == 2**SEL_W.
    localparam logic [SEL_W:0] NUM_SEL_V = (SEL_W + 1)'(NUM_SEL);
    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_SEL-1:0]  sel_oh_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                ovr_q;

    logic [NUM_SEL-1:0]  sel_oh_d;
    logic                sel_ok;

    // Decode the incoming index; only used when a request is accepted in IDLE.
    always_comb begin
        sel_oh_d = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            sel_oh_d[i] = (sel == SEL_W'(i));
        end
        sel_ok = ({1'b0, sel} < NUM_SEL_V);
    end

    // Access sequencer: every output is a register, reset and abort clear the access without done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_oh_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!ena && req) begin
                        if (sel_ok) begin
                            state_q  <= S_ACTIVE;
                            cnt_q    <= HOLD_V;
                            sel_oh_q <= sel_oh_d;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (ena) begin
                        // Abort beats both completion and overrun reporting.
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        sel_oh_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        if (req) begin
                            ovr_q <= 1'b1;
                        end
                        if (cnt_q == CNT_ONE) begin
                            state_q  <= S_IDLE;
                            cnt_q    <= '0;
                            sel_oh_q <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    sel_oh_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_oh = sel_oh_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign ovr    = ovr_q;

endmodule

// File: tb/tb_uart_reg_select.sv
// Bench for uart_reg_select: four instances cover the default, HOLD_CYC=3, NUM_SEL=3 and HOLD_CYC=4 builds.
// Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
// Expected output vectors are queued as stimulus is applied and popped after each edge.
module tb_uart_reg_select;

    typedef struct packed {
        logic [3:0] oh;
        logic       busy;
        logic       done;
        logic       err;
        logic       ovr;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_v [4];
    logic       ena_v [4];
    logic [1:0] sel_v [4];

    logic [3:0] oh_a, oh_b, oh_d;
    logic [2:0] oh_c;
    logic       busy_a, done_a, err_a, ovr_a;
    logic       busy_b, done_b, err_b, ovr_b;
    logic       busy_c, done_c, err_c, ovr_c;
    logic       busy_d, done_d, err_d, ovr_d;

    obs_t obs [4];
    obs_t exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_reg_select #(.SEL_W(2), .NUM_SEL(4), .HOLD_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .req(req_v[0]), .sel(sel_v[0]),
        .sel_oh(oh_a), .busy(busy_a), .done(done_a), .err(err_a), .ovr(ovr_a));

    uart_reg_select #(.SEL_W(2), .NUM_SEL(4), .HOLD_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .req(req_v[1]), .sel(sel_v[1]),
        .sel_oh(oh_b), .busy(busy_b), .done(done_b), .err(err_b), .ovr(ovr_b));

    uart_reg_select #(.SEL_W(2), .NUM_SEL(3), .HOLD_CYC(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[2]), .req(req_v[2]), .sel(sel_v[2]),
        .sel_oh(oh_c), .busy(busy_c), .done(done_c), .err(err_c), .ovr(ovr_c));

    uart_reg_select #(.SEL_W(2), .NUM_SEL(4), .HOLD_CYC(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[3]), .req(req_v[3]), .sel(sel_v[3]),
        .sel_oh(oh_d), .busy(busy_d), .done(done_d), .err(err_d), .ovr(ovr_d));

    assign obs[0] = {oh_a, busy_a, done_a, err_a, ovr_a};
    assign obs[1] = {oh_b, busy_b, done_b, err_b, ovr_b};
    assign obs[2] = {1'b0, oh_c, busy_c, done_c, err_c, ovr_c};
    assign obs[3] = {oh_d, busy_d, done_d, err_d, ovr_d};

    function automatic obs_t mk(logic [3:0] oh, logic b, logic d, logic e, logic o);
        return {oh, b, d, e, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 4; d++) begin
            req_v[d] = 1'b0;
            ena_v[d] = 1'b0;
            sel_v[d] = 2'd0;
        end
    endtask

    // Reset held with an active request on every instance, then released.
    task automatic test_reset();
        obs_t got, want;
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            req_v[d] = 1'b1;
            ena_v[d] = 1'b0;
            sel_v[d] = 2'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                rst_n = 1'b1;
                idle_all();
            end
            for (int d = 0; d < 4; d++) exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
            tick();
            for (int d = 0; d < 4; d++) begin
                got  = obs[d];
                want = exp_q.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL reset dut%0d cyc%0d: got oh/b/d/e/o=%b want %b", d, k, got, want);
                end
            end
        end
    endtask

    // Single accesses with HOLD_CYC=1 for each legal index.
    task automatic test_basic();
        obs_t got, want;
        logic [1:0] s_t [4];
        logic [3:0] oh_t [4];
        s_t  = '{2'd2, 2'd0, 2'd1, 2'd3};
        oh_t = '{4'b0100, 4'b0001, 4'b0010, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                req_v[0] = (k == 0);
                sel_v[0] = (k == 0) ? s_t[i] : 2'd0;
                case (k)
                    0:       exp_q.push_back(mk(oh_t[i], 1, 0, 0, 0));
                    1:       exp_q.push_back(mk(4'b0000, 0, 1, 0, 0));
                    default: exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
                endcase
                tick();
                got  = obs[0];
                want = exp_q.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL basic sel%0d cyc%0d: got oh/b/d/e/o=%b want %b", s_t[i], k, got, want);
                end
            end
        end
    endtask

    // While disabled, requests (legal or not) produce nothing.
    task automatic test_disabled();
        obs_t got, want;
        for (int k = 0; k < 3; k++) begin
            ena_v[0] = (k < 2);
            req_v[0] = (k < 2);
            sel_v[0] = (k == 0) ? 2'd3 : 2'd0;
            exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
            tick();
            got  = obs[0];
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL disabled cyc%0d: got oh/b/d/e/o=%b want %b", k, got, want);
            end
        end
        idle_all();
    endtask

    // HOLD_CYC=3: second request lands in the done cycle of the first.
    task automatic test_back_to_back();
        obs_t got, want;
        logic       r_t [9];
        logic [1:0] s_t [9];
        obs_t       e_t [9];
        r_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s_t = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        e_t = '{mk(4'b0010, 1, 0, 0, 0), mk(4'b0010, 1, 0, 0, 0), mk(4'b0010, 1, 0, 0, 0),
                mk(4'b0000, 0, 1, 0, 0),
                mk(4'b1000, 1, 0, 0, 0), mk(4'b1000, 1, 0, 0, 0), mk(4'b1000, 1, 0, 0, 0),
                mk(4'b0000, 0, 1, 0, 0), mk(4'b0000, 0, 0, 0, 0)};
        for (int k = 0; k < 9; k++) begin
            req_v[1] = r_t[k];
            sel_v[1] = s_t[k];
            exp_q.push_back(e_t[k]);
            tick();
            got  = obs[1];
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL b2b cyc%0d: got oh/b/d/e/o=%b want %b", k, got, want);
            end
        end
    endtask

    // NUM_SEL=3: index 3 flags err, index 2 then works normally.
    task automatic test_range();
        obs_t got, want;
        logic       r_t [6];
        logic [1:0] s_t [6];
        obs_t       e_t [6];
        r_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        s_t = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
        e_t = '{mk(4'b0000, 0, 0, 1, 0), mk(4'b0000, 0, 0, 0, 0),
                mk(4'b0100, 1, 0, 0, 0), mk(4'b0000, 0, 1, 0, 0),
                mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0)};
        for (int k = 0; k < 6; k++) begin
            req_v[2] = r_t[k];
            sel_v[2] = s_t[k];
            exp_q.push_back(e_t[k]);
            tick();
            got  = obs[2];
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL range cyc%0d: got oh/b/d/e/o=%b want %b", k, got, want);
            end
        end
    endtask

    // HOLD_CYC=4: overrun then abort; then abort with req on the last active cycle.
    task automatic test_overrun_abort();
        obs_t got, want;
        logic       r_t [14];
        logic       a_t [14];
        logic [1:0] s_t [14];
        obs_t       e_t [14];
        r_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        a_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        s_t = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        e_t = '{mk(4'b0001, 1, 0, 0, 0), mk(4'b0001, 1, 0, 0, 0), mk(4'b0001, 1, 0, 0, 1),
                mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0),
                mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0),
                mk(4'b0100, 1, 0, 0, 0), mk(4'b0100, 1, 0, 0, 0), mk(4'b0100, 1, 0, 0, 0),
                mk(4'b0100, 1, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0)};
        for (int k = 0; k < 14; k++) begin
            req_v[3] = r_t[k];
            ena_v[3] = a_t[k];
            sel_v[3] = s_t[k];
            exp_q.push_back(e_t[k]);
            tick();
            got  = obs[3];
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL ovr_abort cyc%0d: got oh/b/d/e/o=%b want %b", k, got, want);
            end
        end
        idle_all();
    endtask

    // HOLD_CYC=4: reset in the middle of an access, no done afterwards.
    task automatic test_reset_mid();
        obs_t got, want;
        logic       r_t [7];
        logic       n_t [7];
        logic [1:0] s_t [7];
        obs_t       e_t [7];
        r_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        s_t = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        e_t = '{mk(4'b1000, 1, 0, 0, 0), mk(4'b1000, 1, 0, 0, 0),
                mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0),
                mk(4'b0000, 0, 0, 0, 0), mk(4'b0000, 0, 0, 0, 0)};
        for (int k = 0; k < 7; k++) begin
            req_v[3] = r_t[k];
            sel_v[3] = s_t[k];
            rst_n    = n_t[k];
            exp_q.push_back(e_t[k]);
            tick();
            got  = obs[3];
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got oh/b/d/e/o=%b want %b", k, got, want);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        #1;
        test_reset();
        test_basic();
        test_disabled();
        test_back_to_back();
        test_range();
        test_overrun_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
